// File: rtl/conv_pkg.sv
// Shared definitions for the 3-tap convolution MAC: default widths, tap count and FSM states.
package conv_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned RES_W_DEF  = 16;
  localparam int unsigned TAPS       = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per step, LSB first.
module shift_add_mult
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   product,
  output logic                  last
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [PROD_W-1:0] prod_q, prod_d;
  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;

  // Multiplicand shifts left while the multiplier shifts right; last marks a finished product.
  always_comb begin
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    if (load) begin
      prod_d   = '0;
      mcand_d  = PROD_W'(a);
      mplier_d = b;
      cnt_d    = '0;
      last_d   = 1'b0;
    end else if (step) begin
      if (mplier_q[0]) begin
        prod_d = prod_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      last_d   = (cnt_q == CNT_W'(DATA_W - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
    end else begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  assign product = prod_q;
  assign last    = last_q;

endmodule

// File: rtl/conv3_mac_unit.sv
// 3-tap convolution MAC: sequential multiply of each sample/coefficient pair,
// accumulation, and a saturated registered result with a one-cycle done pulse.
module conv3_mac_unit
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RES_W  = RES_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] x0,
  input  logic [DATA_W-1:0] x1,
  input  logic [DATA_W-1:0] x2,
  input  logic [DATA_W-1:0] h0,
  input  logic [DATA_W-1:0] h1,
  input  logic [DATA_W-1:0] h2,
  output logic              busy,
  output logic              done,
  output logic [RES_W-1:0]  y,
  output logic              ovf
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned ACC_W  = RES_W + 2;
  localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned TAP_W  = $clog2(TAPS);
  localparam logic [ACC_W-1:0] RES_MAX = ACC_W'({RES_W{1'b1}});

  state_e                        state_q, state_d;
  logic [TAP_W-1:0]              tap_q, tap_d;
  logic [BIT_W-1:0]              bit_q, bit_d;
  logic [ACC_W-1:0]              acc_q, acc_d;
  logic [TAPS-2:0][DATA_W-1:0]   x_hold_q, x_hold_d;
  logic [TAPS-2:0][DATA_W-1:0]   h_hold_q, h_hold_d;
  logic [RES_W-1:0]              y_q, y_d;
  logic                          ovf_q, ovf_d;
  logic                          done_q, done_d;
  logic                          busy_q, busy_d;

  logic                          mult_load;
  logic                          mult_step;
  logic [DATA_W-1:0]             mult_a;
  logic [DATA_W-1:0]             mult_b;
  logic [PROD_W-1:0]             mult_product;
  logic                          mult_last;
  logic [ACC_W-1:0]              addend;
  logic [ACC_W-1:0]              sum;

  shift_add_mult #(
    .DATA_W (DATA_W)
  ) u_mult (
    .clk     (clk),
    .rst     (rst),
    .load    (mult_load),
    .step    (mult_step),
    .a       (mult_a),
    .b       (mult_b),
    .product (mult_product),
    .last    (mult_last)
  );

  // Tap 0 goes straight into the multiplier on accept; taps 1 and 2 wait in the hold registers.
  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    bit_d     = bit_q;
    acc_d     = acc_q;
    x_hold_d  = x_hold_q;
    h_hold_d  = h_hold_q;
    y_d       = y_q;
    ovf_d     = ovf_q;
    mult_load = 1'b0;
    mult_step = 1'b0;
    mult_a    = x0;
    mult_b    = h0;
    addend    = mult_last ? ACC_W'(mult_product) : '0;
    sum       = acc_q + addend;

    case (state_q)
      IDLE: begin
        if (start) begin
          x_hold_d  = {x2, x1};
          h_hold_d  = {h2, h1};
          acc_d     = '0;
          tap_d     = '0;
          bit_d     = '0;
          mult_load = 1'b1;
          state_d   = MULT;
        end
      end
      MULT: begin
        mult_step = 1'b1;
        if (bit_q == BIT_W'(DATA_W - 1)) begin
          bit_d   = '0;
          state_d = ACC;
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      ACC: begin
        acc_d = sum;
        if (tap_q == TAP_W'(TAPS - 1)) begin
          ovf_d   = (sum > RES_MAX);
          y_d     = (sum > RES_MAX) ? '1 : sum[RES_W-1:0];
          state_d = DONE;
        end else begin
          // Reload the multiplier with the next tap in the same cycle the product is consumed.
          tap_d     = tap_q + TAP_W'(1);
          bit_d     = '0;
          mult_a    = (tap_q == TAP_W'(0)) ? x_hold_q[0] : x_hold_q[1];
          mult_b    = (tap_q == TAP_W'(0)) ? h_hold_q[0] : h_hold_q[1];
          mult_load = 1'b1;
          state_d   = MULT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tap_q    <= '0;
      bit_q    <= '0;
      acc_q    <= '0;
      x_hold_q <= '0;
      h_hold_q <= '0;
      y_q      <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      bit_q    <= bit_d;
      acc_q    <= acc_d;
      x_hold_q <= x_hold_d;
      h_hold_q <= h_hold_d;
      y_q      <= y_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign y    = y_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_conv3_mac_unit.sv
// Self-checking bench for conv3_mac_unit: cycle-level reference model plus directed scenarios.
module tb_conv3_mac_unit;

  localparam int DW   = 8;
  localparam int RW   = 16;
  localparam int LAT  = 3 * (DW + 1) + 1;
  localparam int MAXV = (1 << RW) - 1;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] x0 = '0, x1 = '0, x2 = '0;
  logic [DW-1:0] h0 = '0, h1 = '0, h2 = '0;
  logic          busy, done, ovf;
  logic [RW-1:0] y;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  int done_cyc[$];

  // Reference model: cycles elapsed since the accepting edge, and the pending result.
  int            m_cnt = 0;
  int            m_sum = 0;
  logic [RW-1:0] m_y   = '0;
  logic          m_ovf = 1'b0;

  conv3_mac_unit #(.DATA_W(DW), .RES_W(RW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x0    (x0),
    .x1    (x1),
    .x2    (x2),
    .h0    (h0),
    .h1    (h1),
    .h2    (h2),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0;
      m_y   <= '0;
      m_ovf <= 1'b0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_cnt <= 1;
        m_sum <= int'(x0) * int'(h0) + int'(x1) * int'(h1) + int'(x2) * int'(h2);
      end
    end else if (m_cnt == LAT) begin
      m_cnt <= 0;
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == LAT - 1) begin
        m_y   <= (m_sum > MAXV) ? RW'(MAXV) : RW'(m_sum);
        m_ovf <= (m_sum > MAXV);
      end
    end
  end

  // Per-cycle compare against the model, sampled away from the active edge.
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_cnt != 0));
    chk("done", 32'(done), 32'(m_cnt == LAT));
    chk("y",    32'(y),    32'(m_y));
    chk("ovf",  32'(ovf),  32'(m_ovf));
    if (done === 1'b1) done_cyc.push_back(cyc);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ops(input int a0, input int a1, input int a2,
                         input int b0, input int b1, input int b2);
    x0 = DW'(a0); x1 = DW'(a1); x2 = DW'(a2);
    h0 = DW'(b0); h1 = DW'(b1); h2 = DW'(b2);
  endtask

  task automatic launch(input int a0, input int a1, input int a2,
                        input int b0, input int b1, input int b2);
    set_ops(a0, a1, a2, b0, b1, b2);
    start = 1'b1;
    t0 = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic check_one(input string nm, input int ey, input int eo);
    chk({nm, "_ndone"}, 32'(done_cyc.size()), 32'd1);
    if (done_cyc.size() > 0) chk({nm, "_lat"}, 32'(done_cyc[0] - t0), 32'd28);
    chk({nm, "_y"},   32'(y),   32'(ey));
    chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  initial begin
    tick(3);
    chk("rst_y",    32'(y),    32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf",  32'(ovf),  32'd0);
    rst = 1'b0;
    tick(2);

    done_cyc.delete();
    launch(1, 2, 3, 4, 5, 6);
    tick(32);
    check_one("basic", 32, 0);

    done_cyc.delete();
    launch(255, 255, 0, 255, 2, 0);
    tick(32);
    check_one("edge", 65535, 0);

    done_cyc.delete();
    launch(255, 255, 255, 255, 255, 255);
    tick(32);
    check_one("sat", 65535, 1);

    done_cyc.delete();
    launch(0, 0, 0, 0, 0, 0);
    tick(32);
    check_one("zero", 0, 0);

    // Start pulses and operand changes while busy, including the DONE cycle.
    done_cyc.delete();
    launch(1, 2, 3, 4, 5, 6);
    tick(4);
    start = 1'b1; x0 = DW'(200);
    tick(1);
    start = 1'b0;
    tick(22);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(10);
    check_one("ignore", 32, 0);

    // Reset in cycle 12 aborts the operation with no done pulse.
    done_cyc.delete();
    launch(255, 255, 255, 255, 255, 255);
    tick(11);
    rst = 1'b1;
    #1;
    chk("abort_y",    32'(y),    32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ovf",  32'(ovf),  32'd0);
    tick(1);
    rst = 1'b0;
    tick(30);
    chk("abort_nodone", 32'(done_cyc.size()), 32'd0);

    done_cyc.delete();
    launch(10, 0, 0, 10, 0, 0);
    tick(32);
    check_one("after_rst", 100, 0);

    // Start held high: back-to-back operations every 29 cycles.
    done_cyc.delete();
    set_ops(2, 2, 2, 3, 3, 3);
    start = 1'b1;
    t0 = cyc;
    tick(59);
    start = 1'b0;
    tick(35);
    chk("held_ndone", 32'(done_cyc.size()), 32'd3);
    if (done_cyc.size() >= 2) begin
      chk("held_lat0", 32'(done_cyc[0] - t0), 32'd28);
      chk("held_lat1", 32'(done_cyc[1] - t0), 32'd57);
    end
    chk("held_y",   32'(y),   32'd18);
    chk("held_ovf", 32'(ovf), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv3_mac_unit.md
CONV3_MAC_UNIT -- requirements
Module: conv3_mac_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 8, sample and coefficient width (unsigned).
REQ-002 SHALL have parameter RES_W, default 16, result width; it matches the 16-bit result register downstream.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request a new 3-tap convolution; accepted only in IDLE.
REQ-006 SHALL have ports x0, x1, x2, inputs, DATA_W each: samples, captured on the accepting edge.
REQ-007 SHALL have ports h0, h1, h2, inputs, DATA_W each: coefficients, captured on the accepting edge.
REQ-008 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking y and ovf valid.
REQ-010 SHALL have port y, output, RES_W bits: saturated sum x0*h0 + x1*h1 + x2*h2.
REQ-011 SHALL have port ovf, output, 1 bit: the true sum exceeded 2^RES_W - 1.

Function
REQ-012 SHALL implement the states IDLE, MULT, ACC and DONE.
REQ-013 IDLE with start=1 SHALL, on the next edge, capture all six operands, clear the accumulator (RES_W+2 bits), set tap=0 and bit=0, and go to MULT.
REQ-014 MULT SHALL do one shift-add step per cycle on the 2*DATA_W partial product, LSB of the multiplier first, for exactly DATA_W cycles, then go to ACC.
REQ-015 ACC SHALL take one cycle to add the product to the accumulator; if tap<2 it increments tap and returns to MULT, otherwise it goes to DONE.
REQ-016 DONE SHALL last one cycle, assert done=1, and return to IDLE.
REQ-017 SHALL assert done exactly 3*(DATA_W+1)+1 cycles after the start-accepting cycle: start high in cycle 0 gives done high in cycle 28 for DATA_W=8.
REQ-018 y and ovf SHALL update on the edge entering DONE and hold until the next entry to DONE or reset.
REQ-019 Saturation: when the accumulator exceeds 2^RES_W-1, y SHALL be all ones and ovf=1; otherwise y is the exact sum and ovf=0.
REQ-020 start while busy=1, including the DONE cycle, SHALL be ignored, with no queuing.
REQ-021 Operand input changes after capture SHALL NOT affect the result in progress.
REQ-022 start held high continuously SHALL launch a new operation on the first IDLE cycle after DONE, giving back-to-back results every 29 cycles.
REQ-023 Zero operands SHALL still take the full latency; there is no early termination.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, busy=0, done=0, y=0, ovf=0, and clear the accumulator, partial product, tap and bit counters.
REQ-025 Reset mid-operation SHALL abort with no done pulse, and the first start after rst falls SHALL be accepted normally.

Structure
REQ-026 Package conv_pkg SHALL hold the state enum, the DATA_W/RES_W defaults and the constant TAPS=3.
REQ-027 The sequential shift-add multiplier datapath SHALL be the sub-module shift_add_mult, with inputs load/step, outputs product/last, and the same clk/rst.
REQ-028 y SHALL be registered inside this block so it drives the downstream 16-bit register directly.

Verification
REQ-029 x=(1,2,3), h=(4,5,6), start pulse in cycle 0 -> busy in cycles 1..28, done only in cycle 28, y=32, ovf=0.
REQ-030 x=(255,255,0), h=(255,2,0) -> y=65535 (16'hFFFF), ovf=0 (exact boundary).
REQ-031 All operands 255 -> true sum 195075, y=16'hFFFF, ovf=1.
REQ-032 After x=(1,2,3), h=(4,5,6) accepted: start pulses and x0=200 changes in cycles 5 and 28 -> ignored, result still y=32, a single done.
REQ-033 rst asserted in cycle 12 of an operation -> y=0, busy=0, no done pulse; a fresh start afterwards with x=(10,0,0), h=(10,0,0) -> y=100 at latency 28.
REQ-034 start held high with constant operands (2,2,2)x(3,3,3) -> done in cycles 28 and 57, y=18 each time.
